// File: rtl/ps2_key_event.sv
// PS/2 set-2 scan-code consumer: pops bytes from the receiver FIFO, folds E0/F0 prefixes
// into held-key state, and emits press/repeat/release pulses plus a press counter.
module ps2_key_event #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         fifo_data,
  input  logic               fifo_ready,
  output logic               fifo_nextdata_n,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_valid,
  output logic               press_pulse,
  output logic               repeat_pulse,
  output logic               release_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_byte;
  logic       r_ext_pend;
  logic       r_brk_pend;

  logic w_is_e0;
  logic w_is_f0;
  logic w_discard;
  logic w_match;

  assign w_is_e0   = (r_byte == 8'hE0);
  assign w_is_f0   = (r_byte == 8'hF0);
  assign w_discard = (r_byte == 8'h00) || (r_byte == 8'hAA) || (r_byte == 8'hE1) ||
                     (r_byte == 8'hFA) || (r_byte == 8'hFE) || (r_byte == 8'hFF);
  assign w_match   = key_valid && (key_code == r_byte) && (key_ext == r_ext_pend);

  // The decode lands on the edge that leaves GAP, so results appear two edges
  // after fifo_ready is sampled; a reset while in ACK therefore drops the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_byte          <= 8'h00;
      r_ext_pend      <= 1'b0;
      r_brk_pend      <= 1'b0;
      fifo_nextdata_n <= 1'b1;
      key_code        <= 8'h00;
      key_ext         <= 1'b0;
      key_valid       <= 1'b0;
      press_pulse     <= 1'b0;
      repeat_pulse    <= 1'b0;
      release_pulse   <= 1'b0;
      press_count     <= '0;
    end else begin
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fifo_ready) begin
            r_byte          <= fifo_data;
            fifo_nextdata_n <= 1'b0;
            r_state         <= S_ACK;
          end
        end
        S_ACK: begin
          fifo_nextdata_n <= 1'b1;
          r_state         <= S_GAP;
        end
        S_GAP: begin
          r_state <= S_IDLE;
          if (w_is_e0) begin
            r_ext_pend <= 1'b1;
          end else if (w_is_f0) begin
            r_brk_pend <= 1'b1;
          end else if (w_discard) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end else if (r_brk_pend) begin
            // Breaks of anything but the held key are dropped silently.
            if (w_match) begin
              key_valid     <= 1'b0;
              release_pulse <= 1'b1;
            end
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end else begin
            if (w_match) begin
              repeat_pulse <= 1'b1;
            end else begin
              key_code    <= r_byte;
              key_ext     <= r_ext_pend;
              key_valid   <= 1'b1;
              press_pulse <= 1'b1;
              press_count <= press_count + COUNT_W'(1);
            end
            r_ext_pend <= 1'b0;
          end
        end
        default: begin
          r_state         <= S_IDLE;
          fifo_nextdata_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Randomized bench for ps2_key_event: FIFO model plus a byte-level key-state reference.
module tb_ps2_key_event;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       press_pulse;
  logic       repeat_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  ps2_key_event #(.COUNT_W(8)) dut (
    .clk(clk), .reset(rst),
    .fifo_data(fifo_data), .fifo_ready(fifo_ready), .fifo_nextdata_n(fifo_nextdata_n),
    .key_code(key_code), .key_ext(key_ext), .key_valid(key_valid),
    .press_pulse(press_pulse), .repeat_pulse(repeat_pulse), .release_pulse(release_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Receiver FIFO model: initial block owns wr, the pop process owns rd.
  logic [7:0] mem [0:8191];
  int wr = 0;
  int rd = 0;
  assign fifo_ready = (wr != rd);
  assign fifo_data  = mem[rd[12:0]];

  always @(posedge clk) begin
    if (rst) rd <= wr;
    else if (!fifo_nextdata_n && (wr != rd)) rd <= rd + 1;
  end

  // Protocol monitor: pop strobe spacing, pulse widths, pulse totals.
  int cyc = 0, last_low = -10, nd_lows = 0, err_gap = 0, err_pulse = 0;
  int cnt_press = 0, cnt_rep = 0, cnt_rel = 0;
  logic [2:0] prev_p = 3'b000;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      last_low <= -10;
      prev_p   <= 3'b000;
    end else begin
      if (!fifo_nextdata_n) begin
        nd_lows  <= nd_lows + 1;
        last_low <= cyc;
        if (cyc - last_low < 3) err_gap <= err_gap + 1;
      end
      if (({press_pulse, repeat_pulse, release_pulse} & prev_p) != 3'b000) err_pulse <= err_pulse + 1;
      prev_p    <= {press_pulse, repeat_pulse, release_pulse};
      cnt_press <= cnt_press + int'(press_pulse);
      cnt_rep   <= cnt_rep + int'(repeat_pulse);
      cnt_rel   <= cnt_rel + int'(release_pulse);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: one tracked key, pending prefixes, press total modulo 256.
  logic [7:0] m_code;
  logic       m_ext, m_valid, m_ep, m_bp;
  logic [7:0] m_cnt;

  task automatic model_reset();
    m_code = 8'h00; m_ext = 1'b0; m_valid = 1'b0; m_ep = 1'b0; m_bp = 1'b0; m_cnt = 8'h00;
  endtask

  function automatic bit is_special(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  // Returns expected {press, repeat, release} for one byte.
  task automatic model_byte(input logic [7:0] b, output logic [2:0] pl);
    bit same;
    pl = 3'b000;
    same = m_valid && (m_code == b) && (m_ext == m_ep);
    if (b == 8'hE0) m_ep = 1'b1;
    else if (b == 8'hF0) m_bp = 1'b1;
    else if (is_special(b)) begin m_ep = 1'b0; m_bp = 1'b0; end
    else begin
      if (m_bp) begin
        if (same) begin m_valid = 1'b0; pl = 3'b001; end
      end else if (same) pl = 3'b010;
      else begin
        m_code = b; m_ext = m_ep; m_valid = 1'b1; m_cnt = m_cnt + 8'd1; pl = 3'b100;
      end
      m_ep = 1'b0; m_bp = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr[12:0]] = b;
    wr++;
  endtask

  task automatic send(input logic [7:0] b);
    logic [2:0] pl;
    int n;
    @(negedge clk);
    push(b);
    n = 0;
    @(negedge clk);
    while (fifo_nextdata_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("pop_seen", 32'(n < 20), 32'd1);
    if (n >= 20) return;
    @(posedge clk); @(posedge clk); @(negedge clk);
    model_byte(b, pl);
    chk("pulses", {press_pulse, repeat_pulse, release_pulse}, pl);
    chk("key", {key_valid, key_ext, key_code}, {m_valid, m_ext, m_code});
    chk("count", press_count, m_cnt);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic make(input bit e, input logic [7:0] c);
    if (e) send(8'hE0);
    send(c);
  endtask

  task automatic brk(input bit e, input logic [7:0] c);
    if (e) send(8'hE0);
    send(8'hF0);
    send(c);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [7:0] keys [0:4] = '{8'h1C, 8'h32, 8'h75, 8'h23, 8'h4B};
  logic [7:0] spl  [0:2] = '{8'hAA, 8'hFA, 8'h00};
  logic [7:0] bl   [0:3] = '{8'h1C, 8'h32, 8'hF0, 8'h32};

  initial begin
    logic [7:0] c;
    logic [2:0] pl;
    int s_lows, s_p, s_rp, s_rl, e_p, e_rp, e_rl, n;
    bit e;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_nd", fifo_nextdata_n, 1);
    chk("rst_key", {key_valid, key_ext, key_code}, 0);
    chk("rst_pulses", {press_pulse, repeat_pulse, release_pulse}, 0);
    chk("rst_count", press_count, 0);

    // press, typematic repeat, release
    make(0, 8'h1C); make(0, 8'h1C); brk(0, 8'h1C);
    chk("rel_keeps_code", key_code, 8'h1C);
    // extended key; bare break of a non-extended 75 must not release it
    make(1, 8'h75); brk(0, 8'h75); brk(1, 8'h75); make(0, 8'h75);
    chk("ext_count", press_count, 3);
    // replacement: break of the old key ignored
    make(0, 8'h1C); make(0, 8'h32); brk(0, 8'h1C);
    chk("replace_held", {key_valid, key_code}, {1'b1, 8'h32});

    // 256 make/break pairs with discarded bytes between them: counter wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do c = 8'($urandom_range(1, 255)); while (is_special(c) || c == 8'hE0 || c == 8'hF0);
      e = 1'($urandom_range(0, 1));
      make(e, c);
      if ($urandom_range(0, 3) == 0) send(spl[$urandom_range(0, 2)]);
      brk(e, c);
    end
    chk("wrap", press_count, 8'h00);

    // random stream over a small key set
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 9);
      c = keys[$urandom_range(0, 4)];
      e = 1'($urandom_range(0, 1));
      if (n < 5) make(e, c);
      else if (n < 8) brk(e, c);
      else send(spl[$urandom_range(0, 2)]);
    end

    // 4-byte backlog with fifo_ready held high
    @(negedge clk);
    s_lows = nd_lows; s_p = cnt_press; s_rp = cnt_rep; s_rl = cnt_rel;
    for (int i = 0; i < 4; i++) push(bl[i]);
    n = 0;
    while (wr != rd && n < 40) begin @(negedge clk); n++; end
    chk("backlog_drain", 32'(n < 40), 1);
    repeat (4) @(negedge clk);
    e_p = 0; e_rp = 0; e_rl = 0;
    for (int i = 0; i < 4; i++) begin
      model_byte(bl[i], pl);
      e_p += int'(pl[2]); e_rp += int'(pl[1]); e_rl += int'(pl[0]);
    end
    chk("backlog_pops", nd_lows - s_lows, 4);
    chk("backlog_press", cnt_press - s_p, e_p);
    chk("backlog_rep", cnt_rep - s_rp, e_rp);
    chk("backlog_rel", cnt_rel - s_rl, e_rl);
    chk("backlog_key", {key_valid, key_ext, key_code}, {m_valid, m_ext, m_code});

    // reset mid-ACK after F0
    make(0, 8'h1C);
    @(negedge clk);
    push(8'hF0);
    n = 0;
    @(negedge clk);
    while (fifo_nextdata_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("ack_seen", 32'(n < 20), 1);
    rst = 1'b1;
    #1;
    chk("ack_rst_nd", fifo_nextdata_n, 1);
    chk("ack_rst_key", {key_valid, key_ext, key_code}, 0);
    chk("ack_rst_count", press_count, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send(8'h1C);
    chk("post_rst_press", {key_valid, press_count}, {1'b1, 8'h01});

    repeat (3) @(negedge clk);
    chk("nd_spacing", err_gap, 0);
    chk("pulse_width", err_pulse, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
